hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, multi-cycle mul/div hold and taken-branch flush.
// Optional stall_cnt output and its counter are built when HAZARD_STALL_COUNT_EN is defined.
module hazard_controller #(
   parameter int REG_BITS   = 5,
   parameter int MULDIV_LAT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [REG_BITS-1:0] IF_ID_RS,
   input  logic [REG_BITS-1:0] IF_ID_RT,
   input  logic                IF_ID_USE_RT,
   input  logic                ID_EX_MEMREAD,
   input  logic [REG_BITS-1:0] ID_EX_RT,
   input  logic                ID_EX_MULDIV,
   input  logic                EX_BRANCH_TAKEN,
   output logic                PC_write,
   output logic                IF_ID_write,
   output logic                ID_EX_bubble,
   output logic                IF_ID_flush,
   output logic                EX_hold,
   output logic                busy,
   output logic [1:0]          state
`ifdef HAZARD_STALL_COUNT_EN
   ,
   output logic [15:0]         stall_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      LOAD   = 2'b01,
      MULDIV = 2'b10,
      FLUSH  = 2'b11
   } state_e;

   localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT - 2);

   if (MULDIV_LAT < 2 || MULDIV_LAT > 15) begin : gLatCheck
      $error("hazard_controller: MULDIV_LAT must be within 2..15");
   end

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       loadUseHit;

   assign loadUseHit = ID_EX_MEMREAD && (ID_EX_RT != '0) &&
                       ((ID_EX_RT == IF_ID_RS) || (IF_ID_USE_RT && (ID_EX_RT == IF_ID_RT)));

   // Next-state and control outputs; reset masks everything back to the idle defaults.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_bubble = 1'b0;
      IF_ID_flush  = 1'b0;
      EX_hold      = 1'b0;
      busy         = 1'b0;
      state        = state_q;

      case (state_q)
         RUN: begin
            if (EX_BRANCH_TAKEN) begin
               IF_ID_flush  = 1'b1;
               ID_EX_bubble = 1'b1;
               state_d      = FLUSH;
            end else if (ID_EX_MULDIV) begin
               EX_hold     = 1'b1;
               PC_write    = 1'b0;
               IF_ID_write = 1'b0;
               busy        = 1'b1;
               cnt_d       = CNT_INIT;
               state_d     = MULDIV;
            end else if (loadUseHit) begin
               PC_write     = 1'b0;
               IF_ID_write  = 1'b0;
               ID_EX_bubble = 1'b1;
               state_d      = LOAD;
            end
         end
         LOAD, FLUSH: begin
            if (EX_BRANCH_TAKEN) begin
               IF_ID_flush  = 1'b1;
               ID_EX_bubble = 1'b1;
               state_d      = FLUSH;
            end else begin
               state_d = RUN;
            end
         end
         MULDIV: begin
            // busy covers only the hold cycles; the counter==0 cycle is the release.
            if (cnt_q != 4'd0) begin
               EX_hold     = 1'b1;
               PC_write    = 1'b0;
               IF_ID_write = 1'b0;
               busy        = 1'b1;
               cnt_d       = cnt_q - 4'd1;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (!rst_n) begin
         state_d      = RUN;
         cnt_d        = 4'd0;
         PC_write     = 1'b1;
         IF_ID_write  = 1'b1;
         ID_EX_bubble = 1'b0;
         IF_ID_flush  = 1'b0;
         EX_hold      = 1'b0;
         busy         = 1'b0;
         state        = RUN;
      end
   end

   // State and hold counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_STALL_COUNT_EN
   logic [15:0] stallCnt_q, stallCnt_d;

   // Counts front-end stall cycles, sticking at all-ones instead of wrapping.
   always_comb begin
      stallCnt_d = stallCnt_q;
      if (!PC_write && (stallCnt_q != 16'hFFFF)) begin
         stallCnt_d = stallCnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCnt_q <= 16'd0;
      end else begin
         stallCnt_q <= stallCnt_d;
      end
   end

   assign stall_cnt = stallCnt_q;
`endif

   // Sanity properties on control combinations that must never occur together.
   aBusyStalls : assert property (@(posedge clk) disable iff (!rst_n) busy |-> (!PC_write && !IF_ID_write));
   aHoldNoFlush : assert property (@(posedge clk) disable iff (!rst_n) EX_hold |-> !IF_ID_flush);
   aFlushNoMul : assert property (@(posedge clk) disable iff (!rst_n)
                                  (state_q == FLUSH) |=> (state_q != MULDIV));

endmodule
